// File: rtl/rrf.sv
// Retirement register file: committed arch-to-phys map (RRAT), returns the
// displaced physical register of every retiring write to the free list, and
// counts retired instructions.
module rrf #(
  parameter int ID_WIDTH = 2,
  parameter int ARF_IDX  = 5,
  parameter int PRF_IDX  = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ID_WIDTH-1:0]                   commit_valid,
  input  logic [ID_WIDTH-1:0][PRF_IDX-1:0]      commit_rd_phy,
  input  logic [ID_WIDTH-1:0][ARF_IDX-1:0]      commit_rd_arch,
  output logic [ID_WIDTH-1:0]                   free_valid,
  output logic [ID_WIDTH-1:0][PRF_IDX-1:0]      free_phy,
  output logic [(2**ARF_IDX)-1:0][PRF_IDX-1:0]  arch_map,
  output logic [63:0]                           retired_cnt
);

  localparam int NARCH = 2**ARF_IDX;

  logic [NARCH-1:0][PRF_IDX-1:0] r_rrat;
  logic [ID_WIDTH-1:0]           r_free_v;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0] r_free_p;
  logic [63:0]                   r_cnt;

  logic [NARCH-1:0][PRF_IDX-1:0] w_rrat_nxt;
  logic [ID_WIDTH-1:0]           w_free_v;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0] w_free_p;
  logic [63:0]                   w_inc;

  // Walk lanes oldest-first so each lane sees the map left by earlier lanes.
  always_comb begin
    w_rrat_nxt = r_rrat;
    w_free_v   = '0;
    w_free_p   = '0;
    w_inc      = '0;
    for (int unsigned i = 0; i < ID_WIDTH; i++) begin
      if (commit_valid[i]) begin
        w_inc = w_inc + 64'd1;
        if (commit_rd_arch[i] != '0) begin
          w_free_v[i]                   = 1'b1;
          w_free_p[i]                   = w_rrat_nxt[commit_rd_arch[i]];
          w_rrat_nxt[commit_rd_arch[i]] = commit_rd_phy[i];
        end
      end
    end
  end

  // Register map, one-cycle free strobes and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned a = 0; a < NARCH; a++) begin
        r_rrat[a] <= PRF_IDX'(a);
      end
      r_free_v <= '0;
      r_free_p <= '0;
      r_cnt    <= '0;
    end else begin
      r_rrat   <= w_rrat_nxt;
      r_free_v <= w_free_v;
      r_free_p <= w_free_p;
      r_cnt    <= r_cnt + w_inc;
    end
  end

  assign free_valid  = r_free_v;
  assign free_phy    = r_free_p;
  assign arch_map    = r_rrat;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_rrf.sv
// Testbench for rrf: directed scenarios plus a random commit stream checked
// against a free-pool / map reference model.
module tb_rrf;

  logic            clk;
  logic            rst;
  logic [1:0]      commit_valid;
  logic [1:0][5:0] commit_rd_phy;
  logic [1:0][4:0] commit_rd_arch;
  logic [1:0]      free_valid;
  logic [1:0][5:0] free_phy;
  logic [31:0][5:0] arch_map;
  logic [63:0]     retired_cnt;

  int checks;
  int errors;

  rrf #(.ID_WIDTH(2), .ARF_IDX(5), .PRF_IDX(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_rd_phy (commit_rd_phy),
    .commit_rd_arch(commit_rd_arch),
    .free_valid    (free_valid),
    .free_phy      (free_phy),
    .arch_map      (arch_map),
    .retired_cnt   (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input logic r, input logic [1:0] v,
                       input logic [4:0] a0, input logic [5:0] p0,
                       input logic [4:0] a1, input logic [5:0] p1);
    rst               = r;
    commit_valid      = v;
    commit_rd_arch[0] = a0;
    commit_rd_phy[0]  = p0;
    commit_rd_arch[1] = a1;
    commit_rd_phy[1]  = p1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    commit_valid = 2'b00;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (free_valid !== 2'b00) begin
      errors++; $display("FAIL reset_free_valid got %b want 00", free_valid);
    end
    checks++;
    if (retired_cnt !== 64'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", retired_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (arch_map[a] !== 6'(a)) begin
        errors++; $display("FAIL reset_map[%0d] got %0d want %0d", a, arch_map[a], a);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    cycle(1'b0, 2'b01, 5'd5, 6'd40, 5'd0, 6'd0);
    checks++;
    if (free_valid !== 2'b01 || free_phy[0] !== 6'd5) begin
      errors++; $display("FAIL single_free got v=%b p0=%0d want v=01 p0=5", free_valid, free_phy[0]);
    end
    checks++;
    if (arch_map[5] !== 6'd40 || retired_cnt !== 64'd1) begin
      errors++; $display("FAIL single_state got map5=%0d cnt=%0d want 40/1", arch_map[5], retired_cnt);
    end
    idle();
    checks++;
    if (free_valid !== 2'b00) begin
      errors++; $display("FAIL single_hold got v=%b want 00", free_valid);
    end
  endtask

  task automatic test_same_arch();
    do_reset();
    cycle(1'b0, 2'b11, 5'd7, 6'd33, 5'd7, 6'd34);
    checks++;
    if (free_valid !== 2'b11 || free_phy[0] !== 6'd7 || free_phy[1] !== 6'd33) begin
      errors++; $display("FAIL same_arch_free got v=%b p0=%0d p1=%0d want 11/7/33",
                         free_valid, free_phy[0], free_phy[1]);
    end
    checks++;
    if (arch_map[7] !== 6'd34 || retired_cnt !== 64'd2) begin
      errors++; $display("FAIL same_arch_state got map7=%0d cnt=%0d want 34/2", arch_map[7], retired_cnt);
    end
  endtask

  task automatic test_arch0();
    do_reset();
    cycle(1'b0, 2'b11, 5'd0, 6'd50, 5'd3, 6'd51);
    checks++;
    if (free_valid !== 2'b10 || free_phy[1] !== 6'd3) begin
      errors++; $display("FAIL arch0_free got v=%b p1=%0d want 10/3", free_valid, free_phy[1]);
    end
    checks++;
    if (arch_map[0] !== 6'd0 || arch_map[3] !== 6'd51 || retired_cnt !== 64'd2) begin
      errors++; $display("FAIL arch0_state got map0=%0d map3=%0d cnt=%0d want 0/51/2",
                         arch_map[0], arch_map[3], retired_cnt);
    end
  endtask

  task automatic test_reset_commit();
    do_reset();
    cycle(1'b0, 2'b01, 5'd9, 6'd20, 5'd0, 6'd0);
    cycle(1'b1, 2'b01, 5'd9, 6'd40, 5'd0, 6'd0);
    idle();
    checks++;
    if (free_valid !== 2'b00 || arch_map[9] !== 6'd9 || retired_cnt !== 64'd0) begin
      errors++; $display("FAIL reset_commit got v=%b map9=%0d cnt=%0d want 00/9/0",
                         free_valid, arch_map[9], retired_cnt);
    end
    // Commit offered in the very first cycle after reset releases.
    do_reset();
    cycle(1'b0, 2'b01, 5'd9, 6'd40, 5'd0, 6'd0);
    checks++;
    if (free_valid !== 2'b01 || free_phy[0] !== 6'd9 || arch_map[9] !== 6'd40 || retired_cnt !== 64'd1) begin
      errors++; $display("FAIL first_after_reset got v=%b p0=%0d map9=%0d cnt=%0d want 01/9/40/1",
                         free_valid, free_phy[0], arch_map[9], retired_cnt);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    cycle(1'b0, 2'b10, 5'd4, 6'd13, 5'd4, 6'd60);
    checks++;
    if (free_valid !== 2'b10 || free_phy[1] !== 6'd4) begin
      errors++; $display("FAIL sparse_first got v=%b p1=%0d want 10/4", free_valid, free_phy[1]);
    end
    cycle(1'b0, 2'b01, 5'd4, 6'd61, 5'd0, 6'd0);
    checks++;
    if (free_valid !== 2'b01 || free_phy[0] !== 6'd60) begin
      errors++; $display("FAIL sparse_second got v=%b p0=%0d want 01/60", free_valid, free_phy[0]);
    end
    checks++;
    if (arch_map[4] !== 6'd61 || retired_cnt !== 64'd2) begin
      errors++; $display("FAIL sparse_state got map4=%0d cnt=%0d want 61/2", arch_map[4], retired_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0]  mmap [32];
    logic [5:0]  pool [$];
    logic [63:0] exp_cnt;
    logic [1:0]  v;
    logic [4:0]  a [2];
    logic [5:0]  p [2];
    logic [1:0]  ef;
    logic [5:0]  ep [2];
    bit          bad;
    do_reset();
    for (int i = 0; i < 32; i++) mmap[i] = 6'(i);
    for (int i = 32; i < 64; i++) pool.push_back(6'(i));
    exp_cnt = 64'd0;
    for (int c = 0; c < 400; c++) begin
      v  = 2'($urandom_range(0, 3));
      ef = 2'b00;
      for (int l = 0; l < 2; l++) begin
        a[l]  = 5'($urandom_range(0, 7));
        p[l]  = 6'($urandom_range(0, 63));
        ep[l] = 6'd0;
        if (v[l] && a[l] != 5'd0) p[l] = pool.pop_front();
      end
      // Reference: retire lanes oldest-first against the current map.
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          exp_cnt = exp_cnt + 64'd1;
          if (a[l] != 5'd0) begin
            ef[l]      = 1'b1;
            ep[l]      = mmap[a[l]];
            mmap[a[l]] = p[l];
          end
        end
      end
      cycle(1'b0, v, a[0], p[0], a[1], p[1]);
      checks++;
      if (free_valid !== ef) begin
        errors++; $display("FAIL rand_free_valid cyc %0d got %b want %b", c, free_valid, ef);
      end
      for (int l = 0; l < 2; l++) begin
        if (ef[l]) begin
          checks++;
          if (free_phy[l] !== ep[l]) begin
            errors++; $display("FAIL rand_free_phy cyc %0d lane %0d got %0d want %0d", c, l, free_phy[l], ep[l]);
          end
          bad = 1'b0;
          for (int r = 0; r < 32; r++) if (mmap[r] == free_phy[l]) bad = 1'b1;
          checks++;
          if (bad) begin
            errors++; $display("FAIL rand_free_mapped cyc %0d lane %0d freed %0d still mapped", c, l, free_phy[l]);
          end
          pool.push_back(ep[l]);
        end
      end
      bad = 1'b0;
      for (int r = 0; r < 32; r++) if (arch_map[r] !== mmap[r]) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++; $display("FAIL rand_map cyc %0d map differs from model", c);
      end
      checks++;
      if (retired_cnt !== exp_cnt) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", c, retired_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    commit_valid   = 2'b00;
    commit_rd_phy  = '0;
    commit_rd_arch = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_same_arch();
    test_arch0();
    test_reset_commit();
    test_sparse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
